// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush controller: hold-level encodings,
// bus widths, reset polarity and controller state encodings.
package pipe_ctrl_pkg;

   localparam int   InstAddrBus = 32;
   localparam int   HoldFlagBus = 3;
   localparam logic ResetEnable = 1'b1;

   typedef logic [HoldFlagBus-1:0] hold_t;

   localparam hold_t Hold_None = 3'd0;
   localparam hold_t Hold_PC   = 3'd1;
   localparam hold_t Hold_IF   = 3'd2;
   localparam hold_t Hold_ID   = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   typedef logic [3:0] flush_cnt_t;

   // State entered after any redirect: a zero-length flush goes straight back to IDLE.
   function automatic state_t redirect_state(input int flush_cycles);
      return (flush_cycles == 0) ? ST_IDLE : ST_FLUSH;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the hazard sources (EX, bus, interrupt controller)
// and pipe_ctrl; master = requesters, slave = pipe_ctrl.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic                   i_jump_flag;
   logic [InstAddrBus-1:0] i_jump_addr;
   logic                   i_hold_flag_ex;
   logic                   i_bus_wait;
   logic                   i_irq_req;
   logic [InstAddrBus-1:0] i_irq_addr;

   hold_t                  o_hold_flag;
   logic                   o_jump_flag;
   logic [InstAddrBus-1:0] o_jump_addr;
   logic                   o_irq_ack;
   logic                   o_timeout;

   modport master (
      output i_jump_flag, i_jump_addr, i_hold_flag_ex, i_bus_wait, i_irq_req, i_irq_addr,
      input  o_hold_flag, o_jump_flag, o_jump_addr, o_irq_ack, o_timeout
   );

   modport slave (
      input  i_jump_flag, i_jump_addr, i_hold_flag_ex, i_bus_wait, i_irq_req, i_irq_addr,
      output o_hold_flag, o_jump_flag, o_jump_addr, o_irq_ack, o_timeout
   );

endinterface

// File: rtl/pipe_ctrl_timer.sv
// Saturating consecutive-stall counter with a sticky timeout flag; only instantiated
// by pipe_ctrl when PIPE_CTRL_TIMEOUT_EN is defined.
module pipe_ctrl_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic i_Clk,
   input  logic i_reset,
   input  logic stall,
   output logic timeout
);

   localparam int            CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntSat  = CntW'(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] stall_cnt_q;

   // The flag sets on the edge closing the TIMEOUT_CYCLES-th stall cycle.
   always_ff @(posedge i_Clk) begin
      if (i_reset) begin
         stall_cnt_q <= '0;
         timeout     <= 1'b0;
      end else begin
         if (!stall)
            stall_cnt_q <= '0;
         else if (stall_cnt_q != CntSat)
            stall_cnt_q <= stall_cnt_q + CntW'(1);
         if (stall && (stall_cnt_q == CntLast))
            timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: Mealy arbitration of redirects, stalls and interrupts
// with a stretched IF flush. Optional stall timeout under PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES   = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        i_Clk,
   input  logic        i_reset,
   pipe_ctrl_if.slave  bus
);

   localparam flush_cnt_t FlushLoad     = flush_cnt_t'(FLUSH_CYCLES);
   localparam state_t     RedirectState = redirect_state(FLUSH_CYCLES);

   state_t                 state_q, state_d;
   flush_cnt_t             flush_cnt_q, flush_cnt_d;
   logic                   rst_act;
   logic                   flush_pend;
   logic                   stall_req;
   hold_t                  hold_flag;
   logic                   jump_flag;
   logic [InstAddrBus-1:0] jump_addr;
   logic                   irq_ack;

   assign rst_act = (i_reset == ResetEnable);

   // A STALL that interrupted a flush keeps its nonzero count and resumes the flush.
   assign flush_pend = (state_q == ST_FLUSH) ||
                       ((state_q == ST_STALL) && (flush_cnt_q != '0));

   always_comb begin
      hold_flag   = Hold_None;
      jump_flag   = 1'b0;
      jump_addr   = '0;
      irq_ack     = 1'b0;
      stall_req   = 1'b0;
      state_d     = ST_IDLE;
      flush_cnt_d = flush_cnt_q;
      if (rst_act) begin
         flush_cnt_d = '0;
      end else if (bus.i_jump_flag) begin
         jump_flag   = 1'b1;
         jump_addr   = bus.i_jump_addr;
         hold_flag   = Hold_ID;
         state_d     = RedirectState;
         flush_cnt_d = FlushLoad;
      end else if (bus.i_hold_flag_ex) begin
         hold_flag = Hold_ID;
         stall_req = 1'b1;
         state_d   = ST_STALL;
      end else if (bus.i_bus_wait) begin
         hold_flag = Hold_PC;
         stall_req = 1'b1;
         state_d   = ST_STALL;
      end else if (flush_pend) begin
         hold_flag   = Hold_IF;
         flush_cnt_d = flush_cnt_q - flush_cnt_t'(1);
         state_d     = (flush_cnt_q == flush_cnt_t'(1)) ? ST_IDLE : ST_FLUSH;
      end else if (bus.i_irq_req) begin
         irq_ack     = 1'b1;
         jump_flag   = 1'b1;
         jump_addr   = bus.i_irq_addr;
         hold_flag   = Hold_ID;
         state_d     = RedirectState;
         flush_cnt_d = FlushLoad;
      end else begin
         flush_cnt_d = '0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (rst_act) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.o_hold_flag = hold_flag;
   assign bus.o_jump_flag = jump_flag;
   assign bus.o_jump_addr = jump_addr;
   assign bus.o_irq_ack   = irq_ack;

`ifdef PIPE_CTRL_TIMEOUT_EN
   logic timeout_q;

   pipe_ctrl_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .i_Clk   (i_Clk),
      .i_reset (rst_act),
      .stall   (stall_req),
      .timeout (timeout_q)
   );

   assign bus.o_timeout = timeout_q & ~rst_act;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) ^ stall_req;
   assign bus.o_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic, checked
// against a cycle-level behavioural model of the hold/redirect rules.
module tb_pipe_ctrl;

   localparam int FC = 2;
   localparam int TO = 8;
`ifdef PIPE_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [2:0]  hold;
      logic        jf;
      logic [31:0] ja;
      logic        ack;
      logic        to;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

   pipe_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT_CYCLES(TO)) dut (
      .i_Clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;

   // Model state: remaining IF-flush cycles, current stall run, sticky timeout.
   int   m_flush = 0;
   int   m_run   = 0;
   bit   m_to    = 1'b0;
   bit   m_ack   = 1'b0;

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, c, act, req);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("hold_flag", e.cyc, 32'(bus.o_hold_flag), 32'(e.hold));
         chk("jump_flag", e.cyc, 32'(bus.o_jump_flag), 32'(e.jf));
         chk("jump_addr", e.cyc, bus.o_jump_addr, e.ja);
         chk("irq_ack",   e.cyc, 32'(bus.o_irq_ack), 32'(e.ack));
         chk("timeout",   e.cyc, 32'(bus.o_timeout), 32'(e.to));
      end
   end

   task automatic step(input bit r, jf, hx, bw, irq, input logic [31:0] ja, ia);
      exp_t e;
      bit   stall;
      @(posedge clk);
      #1;
      cyc++;
      rst                = r;
      bus.i_jump_flag    = jf;
      bus.i_jump_addr    = ja;
      bus.i_hold_flag_ex = hx;
      bus.i_bus_wait     = bw;
      bus.i_irq_req      = irq;
      bus.i_irq_addr     = ia;
      e = '{cyc: cyc, hold: 3'd0, jf: 1'b0, ja: 32'd0, ack: 1'b0, to: TO_EN & m_to};
      stall = 1'b0;
      if (r) begin
         e.to = 1'b0; m_flush = 0; m_run = 0; m_to = 1'b0;
      end else begin
         if (jf) begin
            e.jf = 1'b1; e.ja = ja; e.hold = 3'd3; m_flush = FC;
         end else if (hx) begin
            e.hold = 3'd3; stall = 1'b1;
         end else if (bw) begin
            e.hold = 3'd1; stall = 1'b1;
         end else if (m_flush > 0) begin
            e.hold = 3'd2; m_flush--;
         end else if (irq) begin
            e.ack = 1'b1; e.jf = 1'b1; e.ja = ia; e.hold = 3'd3; m_flush = FC;
         end
         if (stall) begin
            m_run++;
            if (m_run >= TO) m_to = 1'b1;
         end else begin
            m_run = 0;
         end
      end
      m_ack = e.ack;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      bit          irq_hold;
      logic [31:0] irq_vec;
      bus.i_jump_flag = 0; bus.i_jump_addr = 0; bus.i_hold_flag_ex = 0;
      bus.i_bus_wait = 0; bus.i_irq_req = 0; bus.i_irq_addr = 0;

      // Reset with jump and irq asserted: everything must read 0
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 32'hDEAD_BEEF, 32'h0000_0080);
      idle(2);
      // Redirect then stretched IF flush
      step(0, 1, 0, 0, 0, 32'h0000_0100, 32'h0);
      idle(3);
      // EX stall overlapping a bus wait
      step(0, 0, 1, 0, 0, 32'h0, 32'h0);
      step(0, 0, 1, 1, 0, 32'h0, 32'h0);
      step(0, 0, 1, 0, 0, 32'h0, 32'h0);
      step(0, 0, 1, 0, 0, 32'h0, 32'h0);
      idle(1);
      // Interrupt held off by bus wait, then accepted
      step(0, 0, 0, 1, 1, 32'h0, 32'h0000_0080);
      step(0, 0, 0, 1, 1, 32'h0, 32'h0000_0080);
      step(0, 0, 0, 0, 1, 32'h0, 32'h0000_0080);
      idle(3);
      // Back-to-back jumps: second target wins
      step(0, 1, 0, 0, 0, 32'h0000_1000, 32'h0);
      step(0, 1, 0, 0, 0, 32'h0000_2000, 32'h0);
      idle(3);
      // Stall in the middle of a flush freezes and resumes it
      step(0, 1, 0, 0, 0, 32'h0000_3000, 32'h0);
      idle(1);
      step(0, 0, 0, 1, 0, 32'h0, 32'h0);
      step(0, 0, 1, 0, 0, 32'h0, 32'h0);
      idle(2);
      // Interrupt pending during a flush waits for it to finish
      step(0, 1, 0, 0, 0, 32'h0000_4000, 32'h0);
      step(0, 0, 0, 0, 1, 32'h0, 32'h0000_0040);
      step(0, 0, 0, 0, 1, 32'h0, 32'h0000_0040);
      step(0, 0, 0, 0, 1, 32'h0, 32'h0000_0040);
      idle(3);
      // Reset in the middle of a flush leaves no residual hold
      step(0, 1, 0, 0, 0, 32'h0000_5000, 32'h0);
      step(1, 0, 0, 0, 0, 32'h0, 32'h0);
      idle(2);
      // Long bus wait crossing the timeout threshold, then reset clears it
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 32'h0, 32'h0);
      idle(3);
      step(1, 0, 0, 0, 0, 32'h0, 32'h0);
      idle(2);

      // Random traffic; the interrupt source holds its request until the model acks
      irq_hold = 1'b0;
      irq_vec  = 32'h0;
      for (int i = 0; i < 2000; i++) begin
         bit r, jf, hx, bw;
         if (irq_hold && m_ack) irq_hold = 1'b0;
         if (!irq_hold && ($urandom_range(0, 7) == 0)) begin
            irq_hold = 1'b1;
            irq_vec  = $urandom;
         end
         r  = ($urandom_range(0, 63) == 0);
         jf = ($urandom_range(0, 9) == 0);
         hx = ($urandom_range(0, 7) == 0);
         bw = ($urandom_range(0, 5) == 0);
         step(r, jf, hx, bw, irq_hold, $urandom, irq_vec);
      end

      @(negedge clk);
      #1;
      chk("scoreboard_drain", cyc, 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hold/flush controller for the five-stage RISC-V core. It arbitrates redirect and stall requests from EX (branches/jumps, multi-cycle ops), the bus (memory wait) and the interrupt controller. It drives the single hold level consumed by pc_reg, if_id and id_ex, plus the PC redirect. A small state machine stretches the IF/ID flush after a redirect to cover instruction-fetch latency.

## Interface
- FLUSH_CYCLES, 1: extra cycles of Hold_IF after a redirect cycle; legal range 0–15.
- TIMEOUT_CYCLES, 1024: continuous-stall limit; used only with the timeout feature.
- i_Clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high (`ResetEnable` = 1)
- i_jump_flag  in  1  EX requests a redirect this cycle
- i_jump_addr  in  `InstAddrBus` (32)  EX redirect target
- i_hold_flag_ex  in  1  EX multi-cycle op busy
- i_bus_wait  in  1  data bus not ready
- i_irq_req  in  1  interrupt pending (level); held by the requester until acked
- i_irq_addr  in  32  trap vector
- o_hold_flag  out  3  Hold_None=0, Hold_PC=1, Hold_IF=2, Hold_ID=3
- o_jump_flag  out  1  PC redirect strobe
- o_jump_addr  out  32  PC redirect target
- o_irq_ack  out  1  one-cycle interrupt-accept pulse
- o_timeout  out  1  sticky stall-timeout flag

## Operation
- States: IDLE, STALL, FLUSH. Registers: state, flush counter (4 bit), optional stall counter.
- Outputs are Mealy: a function of state plus current inputs. Each cycle, the first matching rule applies (priority order):
  1. i_jump_flag=1, any state:
     - o_jump_flag=1, o_jump_addr=i_jump_addr, o_hold_flag=Hold_ID.
     - Next state FLUSH, counter=FLUSH_CYCLES. If FLUSH_CYCLES=0, next state IDLE.
     - A jump during FLUSH restarts the count.
  2. i_hold_flag_ex=1:
     - o_hold_flag=Hold_ID; next state STALL.
  3. i_bus_wait=1:
     - o_hold_flag=Hold_PC; next state STALL.
  4. State FLUSH:
     - o_hold_flag=Hold_IF; counter decrements.
     - Counter=1 → next state IDLE.
  5. State IDLE or STALL with i_irq_req=1:
     - o_irq_ack=1, o_jump_flag=1, o_jump_addr=i_irq_addr, o_hold_flag=Hold_ID.
     - Next state FLUSH as in rule 1.
  6. Otherwise: Hold_None; next state IDLE.
- Interrupts are never accepted while a jump, stall or flush is active; the request stays pending.
- A stall request that arrives during FLUSH takes priority. The flush counter freezes and resumes once the stall clears: the STALL state remembers a nonzero counter and returns to FLUSH.
- When no redirect is active, o_jump_addr=0. o_irq_ack is never high for more than one cycle per accept.

## Timing
- Reset cycle:
  - All outputs forced to 0 (Hold_None, no jump, addr 0, no ack, o_timeout 0).
  - State IDLE, counters 0. Inputs are ignored.
- Redirect, hold and ack are zero-latency, combinational from the inputs.
- A redirect in cycle N gives Hold_ID in N, then Hold_IF in N+1 … N+FLUSH_CYCLES, then Hold_None.
- Stall release is zero-latency: when the request drops, the same cycle shows Hold_None, or Hold_IF if a flush is pending.
- Reset asserted mid-flush or mid-stall returns to IDLE on the next edge, with no residual hold.

## Configuration
- `PIPE_CTRL_TIMEOUT_EN` defined:
  - A stall counter runs while in STALL and clears on exit.
  - On reaching TIMEOUT_CYCLES consecutive stall cycles, o_timeout sets and stays set until reset.
  - Stalling behaviour is unchanged.
- Not defined: no counter, o_timeout tied 0. The port is always present.

## Structure
- Add the following to the shared defines file: Hold_None/Hold_PC/Hold_IF/Hold_ID encodings, HoldFlagBus width, pipe_ctrl state encodings and ResetEnable.
- One natural sub-module: pipe_ctrl_timer, the saturating stall counter. It is instantiated only under `PIPE_CTRL_TIMEOUT_EN`.

## Test plan
- Reset held 3 cycles with i_jump_flag=1, i_irq_req=1 → all outputs 0; IDLE afterwards.
- FLUSH_CYCLES=2; jump to 0x0000_0100 in cycle 5 → cycle 5: jump_flag=1, addr 0x100, Hold_ID; cycles 6–7 Hold_IF; cycle 8 Hold_None.
- i_hold_flag_ex high cycles 3–6 together with i_bus_wait high in cycle 4 → Hold_ID in cycles 3–6 (EX wins); Hold_None in cycle 7.
- i_irq_req high from cycle 2, bus_wait high in cycles 2–3, irq_addr 0x0000_0080 → o_irq_ack only in cycle 4 with redirect to 0x80; Hold_IF in cycle 5.
- Jump in cycle 10 and again in cycle 11 (FLUSH_CYCLES=1) → second target wins; Hold_IF only in cycle 12.
- With `PIPE_CTRL_TIMEOUT_EN` and TIMEOUT_CYCLES=8, bus_wait held 10 cycles → o_timeout rises after the 8th stall cycle and stays high until i_reset.
